ad724_switch_seq: RTL and testbench

Sequenced PAL/NTSC switch controller for the AD724 video encoder. Replaces the direct-drive encoder control register with a ZXUNO register whose writes trigger a timed, glitch-safe sequence: blank video, swap the crystal select, wait for the encoder to settle, swap the standard select, wait again, then unblank. It sits on the ZXUNO register bus next to the other control registers and drives the AD724 pins plus a blanking request to the video output stage.

---
 rtl/ad724_switch_seq.sv | 172 +++++++++++++++++
 tb/tb_ad724_switch_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad724_switch_seq.sv
// ============================================================================
// ad724_switch_seq : sequenced PAL/NTSC switch controller for the AD724
// encoder. AD724_SAFE_SWITCH_EN enables the blank/xtal/mode sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ad724_switch_seq #(
  parameter logic [7:0] REG_ADDR   = 8'hFB,
  parameter int         BLANK_LEAD = 4096,
  parameter int         SETTLE     = 28000,
  parameter int         CNT_W      = 20
) (
  input  logic       clk,
  input  logic       poweron_rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       ad724_xtal,
  output logic       ad724_mode,
  output logic       video_blank,
  output logic       busy
);

  logic w_sel;
  logic w_wr;
  logic r_target;
  logic r_xtal;
  logic r_mode;
  logic w_unused_din;

  assign w_sel        = (zxuno_addr == REG_ADDR);
  assign w_wr         = w_sel && zxuno_regwr;
  assign oe_n         = ~(w_sel && zxuno_regrd);
  assign w_unused_din = &{1'b0, din[7:1]};
  assign ad724_xtal   = r_xtal;
  assign ad724_mode   = r_mode;

  // Writes are accepted at any time; the sequencer picks up the latest value.
  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) r_target <= 1'b0;
    else if (w_wr)      r_target <= din[0];
  end

`ifdef AD724_SAFE_SWITCH_EN

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_XTAL  = 2'd2,
    S_MODE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_BLANK_LEAD_M1 = CNT_W'(BLANK_LEAD - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_M1     = CNT_W'(SETTLE - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_applied, w_applied_nxt;
  logic             r_seq_target, w_seq_target_nxt;
  logic             w_xtal_nxt, w_mode_nxt;
  logic             r_blank, w_blank_nxt;
  logic             r_busy;
  logic             w_pending;
  logic             w_cnt_zero;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_pending   = r_busy && (r_target != r_seq_target);
  assign video_blank = r_blank;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_applied    <= 1'b0;
      r_seq_target <= 1'b0;
      r_xtal       <= 1'b1;
      r_mode       <= 1'b0;
      r_blank      <= 1'b0;
      r_busy       <= 1'b0;
      dout         <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_applied    <= w_applied_nxt;
      r_seq_target <= w_seq_target_nxt;
      r_xtal       <= w_xtal_nxt;
      r_mode       <= w_mode_nxt;
      r_blank      <= w_blank_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      dout         <= {r_busy, w_pending, 5'b0, r_target};
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_applied_nxt    = r_applied;
    w_seq_target_nxt = r_seq_target;
    w_xtal_nxt       = r_xtal;
    w_mode_nxt       = r_mode;
    w_blank_nxt      = r_blank;
    case (r_state)
      S_IDLE: begin
        if (r_target != r_applied) begin
          w_seq_target_nxt = r_target;
          w_blank_nxt      = 1'b1;
          w_cnt_nxt        = c_BLANK_LEAD_M1;
          w_state_nxt      = S_BLANK;
        end
      end
      S_BLANK: begin
        if (w_cnt_zero) begin
          w_xtal_nxt  = ~r_seq_target;
          w_cnt_nxt   = c_SETTLE_M1;
          w_state_nxt = S_XTAL;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_XTAL: begin
        if (w_cnt_zero) begin
          w_mode_nxt  = r_seq_target;
          w_cnt_nxt   = c_SETTLE_M1;
          w_state_nxt = S_MODE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_MODE: begin
        // Unblank only once the encoder has settled on the new standard.
        if (w_cnt_zero) begin
          w_blank_nxt   = 1'b0;
          w_applied_nxt = r_seq_target;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`else

  localparam int c_unused_cfg = BLANK_LEAD + SETTLE + CNT_W;

  assign video_blank = 1'b0;
  assign busy        = 1'b0;

  // Direct drive: pins follow the register one clock after the write.
  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      r_xtal <= 1'b1;
      r_mode <= 1'b0;
      dout   <= 8'h00;
    end else begin
      r_xtal <= ~r_target;
      r_mode <= r_target;
      dout   <= {7'b0, r_target};
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_ad724_switch_seq.sv
// ============================================================================
// tb_ad724_switch_seq : directed self-checking bench for ad724_switch_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ad724_switch_seq;

  logic       clk;
  logic       poweron_rst_n;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;
  logic       ad724_xtal;
  logic       ad724_mode;
  logic       video_blank;
  logic       busy;

  int checks;
  int errors;

  ad724_switch_seq #(
    .REG_ADDR   (8'hFB),
    .BLANK_LEAD (4),
    .SETTLE     (8),
    .CNT_W      (20)
  ) dut (
    .clk           (clk),
    .poweron_rst_n (poweron_rst_n),
    .zxuno_addr    (zxuno_addr),
    .zxuno_regrd   (zxuno_regrd),
    .zxuno_regwr   (zxuno_regwr),
    .din           (din),
    .dout          (dout),
    .oe_n          (oe_n),
    .ad724_xtal    (ad724_xtal),
    .ad724_mode    (ad724_mode),
    .video_blank   (video_blank),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic       xtal;
    logic       mode;
    logic       blank;
    logic       busy;
    logic [7:0] dout;
  } seq_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic       regrd;
    logic       oe_n;
  } oe_vec_t;

  seq_vec_t seq_tab[9];
  oe_vec_t  oe_tab[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic x, input logic m,
                            input logic b, input logic bz);
    check({tag, " xtal"},  {7'b0, ad724_xtal},  {7'b0, x});
    check({tag, " mode"},  {7'b0, ad724_mode},  {7'b0, m});
    check({tag, " blank"}, {7'b0, video_blank}, {7'b0, b});
    check({tag, " busy"},  {7'b0, busy},        {7'b0, bz});
  endtask

  // Drives a register write for one edge; returns 1 ns after that edge.
  task automatic reg_write(input logic [7:0] data);
    zxuno_addr  = 8'hFB;
    din         = data;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    zxuno_addr  = 8'h00;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    poweron_rst_n = 1'b0;
    zxuno_addr    = 8'h00;
    zxuno_regrd   = 1'b0;
    zxuno_regwr   = 1'b0;
    din           = 8'h00;

`ifdef AD724_SAFE_SWITCH_EN
    // k = cycles after E1 (sampled 1 ns after edge E1+k); BLANK_LEAD=4, SETTLE=8.
    seq_tab[0] = '{0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h01};
    seq_tab[1] = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 8'h81};
    seq_tab[2] = '{3,  1'b1, 1'b0, 1'b1, 1'b1, 8'h81};
    seq_tab[3] = '{4,  1'b0, 1'b0, 1'b1, 1'b1, 8'h81};
    seq_tab[4] = '{11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81};
    seq_tab[5] = '{12, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81};
    seq_tab[6] = '{19, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81};
    seq_tab[7] = '{20, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81};
    seq_tab[8] = '{21, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
`else
    seq_tab[0] = '{0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[1] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[2] = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[3] = '{4,  1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[4] = '{11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[5] = '{12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[6] = '{19, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[7] = '{20, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    seq_tab[8] = '{21, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
`endif
    oe_tab[0] = '{8'hFB, 1'b1, 1'b0};
    oe_tab[1] = '{8'hFB, 1'b0, 1'b1};
    oe_tab[2] = '{8'hFA, 1'b1, 1'b1};
    oe_tab[3] = '{8'h00, 1'b0, 1'b1};

    // Reset state
    tick();
    tick();
    check_pins("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset dout", dout, 8'h00);
    poweron_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_pins("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle dout", dout, 8'h00);

    // Single PAL->NTSC sequence driven from the table
    reg_write(8'h01);
    for (int k = 0; k <= 21; k++) begin
      tick();
      for (int v = 0; v < 9; v++) begin
        if (seq_tab[v].k == k) begin
          check_pins($sformatf("seq k=%0d", k), seq_tab[v].xtal, seq_tab[v].mode,
                     seq_tab[v].blank, seq_tab[v].busy);
          check($sformatf("seq k=%0d dout", k), dout, seq_tab[v].dout);
        end
      end
    end
    for (int i = 0; i < 4; i++) tick();

    // Back to PAL, then a write queued mid-sequence (back-to-back)
    reg_write(8'h00);
    for (int i = 0; i < 30; i++) tick();
    check_pins("to pal", 1'b1, 1'b0, 1'b0, 1'b0);
    reg_write(8'h01);
    for (int k = 0; k <= 41; k++) begin
      if (k == 6) begin
        reg_write(8'h00);
      end else begin
        tick();
      end
`ifdef AD724_SAFE_SWITCH_EN
      if (k == 7)  check("b2b dout pending", dout, 8'hC0);
      if (k == 19) check_pins("b2b k=19", 1'b0, 1'b1, 1'b1, 1'b1);
      if (k == 20) check_pins("b2b k=20 gap", 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 21) check_pins("b2b k=21 restart", 1'b0, 1'b1, 1'b1, 1'b1);
      if (k == 25) check_pins("b2b k=25 xtal", 1'b1, 1'b1, 1'b1, 1'b1);
      if (k == 33) check_pins("b2b k=33 mode", 1'b1, 1'b0, 1'b1, 1'b1);
      if (k == 40) check_pins("b2b k=40", 1'b1, 1'b0, 1'b1, 1'b1);
`else
      if (k == 7)  check("b2b dout", dout, 8'h00);
      if (k == 7)  check_pins("b2b k=7", 1'b1, 1'b0, 1'b0, 1'b0);
`endif
      if (k == 41) check_pins("b2b end", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check("b2b end dout", dout, 8'h00);

    // Redundant write while idle in PAL: nothing moves
    reg_write(8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_pins($sformatf("noop %0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset asserted mid-sequence (XTAL state window)
    reg_write(8'h01);
    for (int i = 0; i < 7; i++) tick();
`ifdef AD724_SAFE_SWITCH_EN
    check_pins("pre-rst", 1'b0, 1'b0, 1'b1, 1'b1);
`else
    check_pins("pre-rst", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    poweron_rst_n = 1'b0;
    #1;
    check_pins("in rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("in rst dout", dout, 8'h00);
    tick();
    poweron_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (video_blank !== 1'b0 || busy !== 1'b0 || ad724_mode !== 1'b0)
        check_pins($sformatf("post-rst %0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_pins("post-rst end", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post-rst dout", dout, 8'h00);

    // Read decode
    for (int v = 0; v < 4; v++) begin
      zxuno_addr  = oe_tab[v].addr;
      zxuno_regrd = oe_tab[v].regrd;
      #1;
      check($sformatf("oe_n addr=%02h rd=%0b", oe_tab[v].addr, oe_tab[v].regrd),
            {7'b0, oe_n}, {7'b0, oe_tab[v].oe_n});
    end
    zxuno_regrd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
